// File: rtl/sw_seq_pkg.sv
// Shared types and default sizes for the switch-vector sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sw_seq_pkg;

  localparam int SEQ_W     = 8;
  localparam int SEQ_DEPTH = 8;
  localparam int PTR_W     = $clog2(SEQ_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/btn_edge.sv
// Button conditioner: 2-FF synchronizer, optional debounce, one-cycle rising-edge pulse.
// Latency: 3 cycles input-to-pulse; SEQ_DEBOUNCE_EN adds DEBOUNCE_CYCLES.
// Backpressure: none; pulses are fire-and-forget.
//
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   btn_i     - raw asynchronous button level
//   rise_o    - one-cycle pulse per accepted rising edge
// Build option: SEQ_DEBOUNCE_EN enables the stability filter.
module btn_edge #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic rise_o
);

  logic sync1_q, sync2_q;
  logic level;
  logic prev_q, rise_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef SEQ_DEBOUNCE_EN
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [DB_W-1:0] db_cnt_q;
  logic            db_lvl_q;

  // Counter runs only while the synchronized input disagrees with the
  // filtered level; any agreement restarts the stability window.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt_q <= '0;
      db_lvl_q <= 1'b0;
    end else if (sync2_q == db_lvl_q) begin
      db_cnt_q <= '0;
    end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      db_cnt_q <= '0;
      db_lvl_q <= sync2_q;
    end else begin
      db_cnt_q <= db_cnt_q + 1'b1;
    end
  end

  assign level = db_lvl_q;
`else
  assign level = sync2_q;
`endif

  // Pulse is registered so the FSM sees a clean flop output.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      prev_q <= level;
      rise_q <= level & ~prev_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/sw_vector_sequencer.sv
// Loads switch vectors, replays them into the sw->led datapath, lets the user browse captured results.
// Latency: HOLD_CYCLES+1 cycles per vector; capture HOLD_CYCLES cycles after dp_in changes.
// Backpressure: none; button edges are ignored while busy.
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   sw                - switches, vector to load / shown on led in IDLE
//   btn_load, btn_run - raw buttons (load/view-next, start/return)
//   dp_in / dp_out    - drive to / response from the datapath
//   led               - board LEDs (sw in IDLE, captured result in DONE)
//   busy, done        - registered status (APPLY/WAIT, DONE)
//   idx               - write pointer in IDLE, read pointer otherwise
// Build option: SEQ_DEBOUNCE_EN adds a button debounce filter.
module sw_vector_sequencer
  import sw_seq_pkg::*;
#(
  parameter int W               = SEQ_W,
  parameter int DEPTH           = SEQ_DEPTH,
  parameter int HOLD_CYCLES     = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [W-1:0]             sw,
  input  logic                     btn_load,
  input  logic                     btn_run,
  output logic [W-1:0]             dp_in,
  input  logic [W-1:0]             dp_out,
  output logic [W-1:0]             led,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH)-1:0] idx
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  logic load_edge, run_edge;

  btn_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_edge (
    .clk    (clk),
    .rst    (rst),
    .btn_i  (btn_load),
    .rise_o (load_edge)
  );

  btn_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_edge (
    .clk    (clk),
    .rst    (rst),
    .btn_i  (btn_run),
    .rise_o (run_edge)
  );

  seq_state_e     state_q, state_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic [W-1:0]   dp_in_q, dp_in_d;
  logic [W-1:0]   led_q, led_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           vec_we, res_we;
  logic [W-1:0]   vec_q [DEPTH];
  logic [W-1:0]   res_q [DEPTH];

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    hold_d   = hold_q;
    dp_in_d  = dp_in_q;
    vec_we   = 1'b0;
    res_we   = 1'b0;

    case (state_q)
      IDLE: begin
        // A run edge swallows a coincident load edge even when it is ignored.
        if (run_edge) begin
          if (count_q != '0) begin
            rd_ptr_d = '0;
            state_d  = APPLY;
          end
        end else if (load_edge) begin
          vec_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (count_q != CW'(DEPTH)) count_d = count_q + 1'b1;
        end
      end
      APPLY: begin
        dp_in_d = vec_q[rd_ptr_q];
        hold_d  = HW'(HOLD_CYCLES - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (hold_q == '0) begin
          res_we = 1'b1;
          if ({1'b0, rd_ptr_q} == count_q - CW'(1)) begin
            rd_ptr_d = '0;
            state_d  = DONE;
          end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            state_d  = APPLY;
          end
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      DONE: begin
        if (run_edge) begin
          state_d = IDLE;
        end else if (load_edge) begin
          // Browse wraps at the number of loaded vectors, not the table size.
          if ({1'b0, rd_ptr_q} + CW'(1) == count_q) rd_ptr_d = '0;
          else                                      rd_ptr_d = rd_ptr_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they land with the state.
    if (state_d == IDLE) dp_in_d = '0;

    busy_d = (state_d == APPLY) || (state_d == WAIT);
    done_d = (state_d == DONE);

    led_d = led_q;
    if (state_d == IDLE) begin
      led_d = sw;
    end else if (state_d == DONE) begin
      // Bypass the result being captured this cycle (single-vector run).
      if (res_we && (rd_ptr_q == rd_ptr_d)) led_d = dp_out;
      else                                  led_d = res_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      hold_q   <= '0;
      dp_in_q  <= '0;
      led_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      hold_q   <= hold_d;
      dp_in_q  <= dp_in_d;
      led_q    <= led_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        vec_q[i] <= '0;
        res_q[i] <= '0;
      end
    end else begin
      if (vec_we) vec_q[wr_ptr_q] <= sw;
      if (res_we) res_q[rd_ptr_q] <= dp_out;
    end
  end

  assign dp_in = dp_in_q;
  assign led   = led_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign idx   = (state_q == IDLE) ? wr_ptr_q : rd_ptr_q;

endmodule

// File: tb/tb_sw_vector_sequencer.sv
`timescale 1ns/1ps
module tb_sw_vector_sequencer;

`ifdef SEQ_DEBOUNCE_EN
  localparam int HOLDP = 30;
`else
  localparam int HOLDP = 4;
`endif

  logic       clk = 1'b0;
  logic       rst, btn_load, btn_run, busy, done;
  logic [7:0] sw, dp_in, dp_out, led;
  logic [2:0] idx;

  int n_chk = 0;
  int n_pass = 0;

  // Reference of what the sequencer should hold: table, write pointer, count.
  logic [7:0] mvec [8];
  int         mwr, mcnt;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  // Stand-in for the Top datapath: a rotate-and-xor.
  function automatic logic [7:0] top_fn(input logic [7:0] x);
    return {x[0], x[7:1]} ^ 8'h5A;
  endfunction

  assign dp_out = top_fn(dp_in);

  sw_vector_sequencer #(.W(8), .DEPTH(8), .HOLD_CYCLES(4), .DEBOUNCE_CYCLES(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .sw       (sw),
    .btn_load (btn_load),
    .btn_run  (btn_run),
    .dp_in    (dp_in),
    .dp_out   (dp_out),
    .led      (led),
    .busy     (busy),
    .done     (done),
    .idx      (idx)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; btn_load = 1'b0; btn_run = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
    mwr = 0; mcnt = 0;
    for (int i = 0; i < 8; i++) mvec[i] = 8'h00;
  endtask

  task automatic press(input bit is_run);
    if (is_run) btn_run = 1'b1; else btn_load = 1'b1;
    tick(HOLDP);
    btn_run = 1'b0; btn_load = 1'b0;
    tick(HOLDP);
  endtask

  task automatic load_vec(input logic [7:0] v);
    sw = v;
    press(1'b0);
    mvec[mwr] = v;
    mwr = (mwr + 1) % 8;
    if (mcnt < 8) mcnt++;
  endtask

  // Starts a run and scores every held dp_in value against the loaded table.
  task automatic do_run(input string tag);
    int k, t;
    logic [7:0] cur;
    exp_q.delete();
    btn_run = 1'b1;
    t = 0;
    while (!busy && t < 80) begin tick(1); t++; end
    btn_run = 1'b0;
    n_chk++;
    if (busy !== 1'b1) begin
      $display("FAIL %s_start: busy=%b after %0d cycles, want 1", tag, busy, t);
      return;
    end
    n_pass++;
    for (int i = 0; i < mcnt; i++) exp_q.push_back(mvec[i]);
    k = 0; cur = dp_in;
    while (busy === 1'b1 && k < 400) begin
      if (k % 5 == 1) cur = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      if ((k % 5 == 0 && k > 0) || k % 5 == 1 || k % 5 == 4) begin
        n_chk++;
        if (dp_in !== cur) $display("FAIL %s_dp_in[%0d]: got %h want %h", tag, k, dp_in, cur);
        else n_pass++;
      end
      tick(1); k++;
    end
    n_chk++;
    if (k != 5 * mcnt || exp_q.size() != 0)
      $display("FAIL %s_busy_len: got %0d cycles (%0d unplayed) want %0d", tag, k, exp_q.size(), 5 * mcnt);
    else n_pass++;
    n_chk++;
    if (done !== 1'b1 || busy !== 1'b0) $display("FAIL %s_done: done=%b busy=%b want 1/0", tag, done, busy);
    else n_pass++;
    n_chk++;
    if (led !== top_fn(mvec[0]) || idx !== 3'd0)
      $display("FAIL %s_first_res: led=%h idx=%0d want %h/0", tag, led, idx, top_fn(mvec[0]));
    else n_pass++;
    n_chk++;
    if (dp_in !== mvec[mcnt - 1]) $display("FAIL %s_dp_hold: got %h want %h", tag, dp_in, mvec[mcnt - 1]);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1; btn_load = 1'b0; btn_run = 1'b0; sw = 8'hC3;
    tick(2);
    n_chk++;
    if (busy !== 1'b0 || done !== 1'b0 || idx !== 3'd0 || dp_in !== 8'h00 || led !== 8'h00)
      $display("FAIL reset: busy=%b done=%b idx=%0d dp_in=%h led=%h want 0/0/0/00/00", busy, done, idx, dp_in, led);
    else n_pass++;
    do_reset();
  endtask

  task automatic test_load();
    logic [7:0] pats [4] = '{8'h00, 8'h01, 8'h03, 8'h81};
    for (int i = 0; i < 4; i++) load_vec(pats[i]);
    n_chk++;
    if (idx !== 3'd4 || busy !== 1'b0) $display("FAIL load_idx: idx=%0d busy=%b want 4/0", idx, busy);
    else n_pass++;
    sw = 8'hA5; tick(2);
    n_chk++;
    if (led !== 8'hA5) $display("FAIL led_follow_a5: got %h want a5", led); else n_pass++;
    sw = 8'h3C; tick(2);
    n_chk++;
    if (led !== 8'h3C) $display("FAIL led_follow_3c: got %h want 3c", led); else n_pass++;
  endtask

  task automatic test_view();
    int e;
    for (int i = 0; i < 4; i++) begin
      press(1'b0);
      e = (i + 1) % mcnt;
      n_chk++;
      if (led !== top_fn(mvec[e]) || idx !== 3'(e))
        $display("FAIL view[%0d]: led=%h idx=%0d want %h/%0d", i, led, idx, top_fn(mvec[e]), e);
      else n_pass++;
    end
    press(1'b1);
    n_chk++;
    if (done !== 1'b0 || busy !== 1'b0 || dp_in !== 8'h00 || led !== sw || idx !== 3'(mwr))
      $display("FAIL return_idle: done=%b busy=%b dp_in=%h led=%h idx=%0d want 0/0/00/%h/%0d",
               done, busy, dp_in, led, idx, sw, mwr);
    else n_pass++;
  endtask

  task automatic check_empty_run(input string tag);
    bit seen;
    seen = 1'b0;
    btn_run = 1'b1;
    for (int i = 0; i < 2 * HOLDP; i++) begin
      tick(1);
      if (busy !== 1'b0 || done !== 1'b0) seen = 1'b1;
      if (i == HOLDP) btn_run = 1'b0;
    end
    n_chk++;
    if (seen || idx !== 3'd0) $display("FAIL %s: left idle=%b idx=%0d want 0/0", tag, seen, idx);
    else n_pass++;
  endtask

  task automatic test_empty_and_simul();
    do_reset();
    check_empty_run("run_empty");
    load_vec(8'h22);
    load_vec(8'h33);
    sw = 8'h44;
    btn_load = 1'b1;
    do_run("simul");
    btn_load = 1'b0;
    tick(HOLDP);
    press(1'b1);
    n_chk++;
    if (idx !== 3'd2) $display("FAIL simul_load_dropped: idx=%0d want 2", idx); else n_pass++;
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 9; i++) load_vec(8'h10 + 8'(i));
    n_chk++;
    if (idx !== 3'd1) $display("FAIL wrap_idx: got %0d want 1", idx); else n_pass++;
    do_run("wrap");
    press(1'b1);
  endtask

  task automatic test_reset_mid();
    int t;
    btn_run = 1'b1;
    t = 0;
    while (!busy && t < 80) begin tick(1); t++; end
    btn_run = 1'b0;
    tick(7);
    n_chk++;
    if (busy !== 1'b1) $display("FAIL mid_pre: busy=%b want 1", busy); else n_pass++;
    rst = 1'b1;
    tick(1);
    n_chk++;
    if (busy !== 1'b0 || done !== 1'b0 || dp_in !== 8'h00 || idx !== 3'd0 || led !== 8'h00)
      $display("FAIL mid_reset: busy=%b done=%b dp_in=%h idx=%0d led=%h want 0/0/00/0/00",
               busy, done, dp_in, idx, led);
    else n_pass++;
    rst = 1'b0;
    tick(1);
    mwr = 0; mcnt = 0;
    check_empty_run("mid_count_zero");
  endtask

  task automatic test_glitch();
    do_reset();
    sw = 8'h77;
`ifdef SEQ_DEBOUNCE_EN
    btn_load = 1'b1; tick(5); btn_load = 1'b0; tick(40);
    n_chk++;
    if (idx !== 3'd0) $display("FAIL short_pulse: idx=%0d want 0", idx); else n_pass++;
    btn_load = 1'b1; tick(20); btn_load = 1'b0; tick(40);
    n_chk++;
    if (idx !== 3'd1) $display("FAIL long_pulse: idx=%0d want 1", idx); else n_pass++;
`else
    btn_load = 1'b1; tick(1); btn_load = 1'b0; tick(8);
    n_chk++;
    if (idx !== 3'd1) $display("FAIL one_cycle_pulse: idx=%0d want 1", idx); else n_pass++;
    btn_load = 1'b1; tick(12); btn_load = 1'b0; tick(8);
    n_chk++;
    if (idx !== 3'd2) $display("FAIL long_level: idx=%0d want 2", idx); else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_load();
    do_run("run4");
    test_view();
    test_empty_and_simul();
    test_wrap();
    test_reset_mid();
    test_glitch();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
